// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle sequencer driving the shared datapath enables and mux selects
module multicycle_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_ctrl,
    output logic [2:0]  imm_src,
    output logic [1:0]  result_src,
    output logic        illegal,
    output logic [3:0]  state
);
    typedef enum logic [3:0] {
        S_RESET  = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC_R = 4'd7,
        S_EXEC_I = 4'd8,  S_ALUWB  = 4'd9,  S_BRANCH = 4'd10, S_JAL    = 4'd11,
        S_LUI    = 4'd12, S_TRAP   = 4'd15
    } state_t;

    state_t     r_state, w_next;
    logic [6:0] w_op, w_f7;
    logic [2:0] w_f3;
    logic       w_r_ok, w_i_ok, w_unused;

    assign w_op     = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];
    assign w_unused = &{1'b0, instr[24:15], instr[11:7]};
    assign state    = r_state;

    // R-type: add/sub need an exact funct7, slt only the base encoding, and/or take any funct7
    assign w_r_ok = (w_f3 == 3'd0 && (w_f7 == 7'h00 || w_f7 == 7'h20)) ||
                    w_f3 == 3'd7 || w_f3 == 3'd6 || (w_f3 == 3'd2 && w_f7 == 7'h00);
    assign w_i_ok = w_f3 == 3'd0 || w_f3 == 3'd7 || w_f3 == 3'd6 || w_f3 == 3'd2;

    // state register; the async reset abandons any memory transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RESET;
        else        r_state <= w_next;
    end

    // next state plus Moore outputs; FETCH/BRANCH write strobes are Mealy on mem_ready/zero
    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_ctrl   = 3'd0;
        imm_src    = 3'd0;
        result_src = 2'd0;
        illegal    = 1'b0;
        case (r_state)
            S_RESET:  w_next = S_FETCH;
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                w_next     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                imm_src   = 3'd2;
                w_next    = ((w_op == 7'h03 || w_op == 7'h23) && w_f3 == 3'd2) ? S_MEMADR :
                            w_op == 7'h33 ? S_EXEC_R :
                            w_op == 7'h13 ? S_EXEC_I :
                            (w_op == 7'h63 && w_f3[2:1] == 2'b00) ? S_BRANCH :
                            w_op == 7'h6F ? S_JAL :
                            w_op == 7'h37 ? S_LUI : S_TRAP;
            end
            S_MEMADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                imm_src   = (w_op == 7'h23) ? 3'd1 : 3'd0;
                w_next    = (w_op == 7'h03) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                w_next  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                result_src = 2'd1;
                reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                w_next  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC_R: begin
                alu_src_a = 2'd2;
                alu_ctrl  = w_f3 == 3'd7 ? 3'd2 : w_f3 == 3'd6 ? 3'd3 : w_f3 == 3'd2 ? 3'd5 :
                            w_f7 == 7'h20 ? 3'd1 : 3'd0;
                w_next    = w_r_ok ? S_ALUWB : S_TRAP;
            end
            S_EXEC_I: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                alu_ctrl  = w_f3 == 3'd7 ? 3'd2 : w_f3 == 3'd6 ? 3'd3 : w_f3 == 3'd2 ? 3'd5 : 3'd0;
                w_next    = w_i_ok ? S_ALUWB : S_TRAP;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'd2;
                alu_ctrl  = 3'd1;
                pc_write  = w_f3[0] ? !zero : zero;
                w_next    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                pc_write  = 1'b1;
                w_next    = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'd3;
                alu_src_b = 2'd1;
                imm_src   = 3'd4;
                w_next    = S_ALUWB;
            end
            S_TRAP:   illegal = 1'b1;
            default:  w_next = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and random instruction streams checked against a per-instruction state-sequence model
module tb_multicycle_controller;
    logic        clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  alu_ctrl, imm_src;
    logic [3:0]  state;
    int          n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .imm_src(imm_src), .result_src(result_src), .illegal(illegal),
        .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total += 1;
        assert (obs === exp) n_pass += 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // instruction class: 0 lw, 1 sw, 2 R, 3 I, 4 branch, 5 jal, 6 lui, 7 unsupported
    function automatic int kind(input logic [31:0] i);
        if (i[6:0] == 7'h03 && i[14:12] == 3'd2) return 0;
        if (i[6:0] == 7'h23 && i[14:12] == 3'd2) return 1;
        if (i[6:0] == 7'h33) return 2;
        if (i[6:0] == 7'h13) return 3;
        if (i[6:0] == 7'h63 && i[14:12] <= 3'd1) return 4;
        if (i[6:0] == 7'h6F) return 5;
        if (i[6:0] == 7'h37) return 6;
        return 7;
    endfunction

    // ALU operation an R/I instruction asks for, -1 when the operation is unsupported
    function automatic int alu_exp(input logic [31:0] i);
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        if (i[6:0] == 7'h33) begin
            if (f3 == 3'd0) return f7 == 7'h00 ? 0 : f7 == 7'h20 ? 1 : -1;
            if (f3 == 3'd7) return 2;
            if (f3 == 3'd6) return 3;
            if (f3 == 3'd2) return f7 == 7'h00 ? 5 : -1;
            return -1;
        end
        if (f3 == 3'd0) return 0;
        if (f3 == 3'd7) return 2;
        if (f3 == 3'd6) return 3;
        if (f3 == 3'd2) return 5;
        return -1;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        int          k = $urandom_range(0, 9);
        int          p = $urandom_range(0, 3);
        logic [2:0]  f3 = p == 0 ? 3'd0 : p == 1 ? 3'd7 : p == 2 ? 3'd6 : 3'd2;
        case (k)
            0: begin r[14:12] = 3'd2; r[6:0] = 7'h03; end
            1: begin r[14:12] = 3'd2; r[6:0] = 7'h23; end
            2: begin r[14:12] = f3; r[31:25] = (f3 == 3'd0 && r[0]) ? 7'h20 : 7'h00; r[6:0] = 7'h33; end
            3: begin r[31:25] = r[1] ? r[31:25] : (r[2] ? 7'h20 : 7'h00); r[6:0] = 7'h33; end
            4: r[6:0] = 7'h13;
            5: begin r[14:12] = {2'b00, r[12]}; r[6:0] = 7'h63; end
            6: r[6:0] = 7'h6F;
            7: r[6:0] = 7'h37;
            8: ;
            default: r[6:0] = r[3] ? 7'h03 : 7'h63;
        endcase
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_illegal", illegal, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_state", state, 0);
        chk("rel_req", mem_req, 0);
    endtask

    // runs one instruction from FETCH with fw fetch waits and mw data-memory waits
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic z);
        int   q[$];
        int   k = kind(ins);
        int   a = alu_exp(ins);
        logic rdy;
        logic tk = (ins[14:12] == 3'd0) ? z : !z;
        for (int i = 0; i <= fw; i++) q.push_back(1);
        q.push_back(2);
        case (k)
            0: begin q.push_back(3); for (int i = 0; i <= mw; i++) q.push_back(4); q.push_back(5); end
            1: begin q.push_back(3); for (int i = 0; i <= mw; i++) q.push_back(6); end
            2: begin q.push_back(7); q.push_back(a < 0 ? 15 : 9); end
            3: begin q.push_back(8); q.push_back(a < 0 ? 15 : 9); end
            4: q.push_back(10);
            5: begin q.push_back(11); q.push_back(9); end
            6: begin q.push_back(12); q.push_back(9); end
            default: q.push_back(15);
        endcase
        for (int n = 0; n < q.size(); n++) begin
            int s = q[n];
            @(negedge clk);
            instr = ins;
            rdy = (s == 1 || s == 4 || s == 6) ? (n + 1 == q.size() || q[n + 1] != s) : 1'($urandom);
            mem_ready = rdy;
            zero = (s == 10) ? z : 1'($urandom);
            #1;
            chk("state", state, s);
            chk("mem_req", mem_req, s == 1 || s == 4 || s == 6);
            chk("mem_we", mem_we, s == 6);
            chk("adr_src", adr_src, s == 4 || s == 6);
            chk("ir_write", ir_write, s == 1 && rdy);
            chk("pc_write", pc_write, (s == 1 && rdy) || s == 11 || (s == 10 && tk));
            chk("reg_write", reg_write, s == 5 || s == 9);
            chk("illegal", illegal, s == 15);
            case (s)
                1: begin chk("fetch_b", alu_src_b, 2); chk("fetch_res", result_src, 2); chk("fetch_alu", alu_ctrl, 0); end
                2: begin chk("dec_a", alu_src_a, 1); chk("dec_b", alu_src_b, 1); chk("dec_imm", imm_src, 2); end
                3: begin chk("adr_a", alu_src_a, 2); chk("adr_imm", imm_src, k == 1); chk("adr_alu", alu_ctrl, 0); end
                5: chk("memwb_res", result_src, 1);
                7, 8: begin
                    chk("exec_a", alu_src_a, 2);
                    chk("exec_b", alu_src_b, s == 8);
                    if (a >= 0) chk("exec_alu", alu_ctrl, a);
                end
                9: chk("aluwb_res", result_src, 0);
                10: begin chk("br_alu", alu_ctrl, 1); chk("br_a", alu_src_a, 2); end
                11: begin chk("jal_a", alu_src_a, 1); chk("jal_b", alu_src_b, 2); end
                12: begin chk("lui_a", alu_src_a, 3); chk("lui_imm", imm_src, 4); end
                default: ;
            endcase
        end
        if (q[q.size() - 1] == 15) begin
            repeat (10) begin
                @(negedge clk);
                mem_ready = 1'($urandom);
                zero = 1'($urandom);
                #1;
                chk("trap_state", state, 15);
                chk("trap_illegal", illegal, 1);
                chk("trap_req", mem_req, 0);
                chk("trap_pc", pc_write, 0);
            end
            do_reset();
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("init_state", state, 0);
        chk("init_req", mem_req, 0);
        chk("init_regw", reg_write, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_rel_state", state, 0);
        run_instr(32'h00500093, 0, 0, 1'b0);
        run_instr(32'h0000A103, 0, 3, 1'b0);
        run_instr(32'h00209463, 0, 0, 1'b0);
        run_instr(32'h00209463, 1, 0, 1'b1);
        run_instr(32'h402081B3, 0, 0, 1'b0);
        run_instr(32'h008000EF, 0, 0, 1'b0);
        run_instr(32'h0020A223, 2, 1, 1'b0);
        run_instr(32'h123450B7, 0, 0, 1'b0);
        instr = 32'h0000A103;
        @(negedge clk); mem_ready = 1'b1; #1; chk("mid_fetch", state, 1);
        @(negedge clk); #1; chk("mid_dec", state, 2);
        @(negedge clk); #1; chk("mid_adr", state, 3);
        @(negedge clk); mem_ready = 1'b0; #1; chk("mid_rd", state, 4); chk("mid_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_adr", adr_src, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_state", state, 0);
        run_instr(32'h022081B3, 0, 0, 1'b0);
        run_instr(32'h0000007F, 0, 0, 1'b0);
        for (int t = 0; t < 300; t++)
            run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
